// File: rtl/line_follower_ctrl.sv
// Purpose: N-sensor line follower with debounce, steering FSM, lost-line search, marker counting and PWM drive.
// Latency: a raw sensor change held stable reaches in1..in4 after DEBOUNCE_CYCLES+3 clock edges.
// Backpressure: none; free-running control loop, enable=0 returns to IDLE on the next edge.
// Ports: clk/rst_n (sync active-low), enable, sensors[N_SENSORS], stop_marks, speed_fast/speed_slow ->
//        in1..in4 H-bridge direction, ena/enb PWM enables, marker_count, lost (sticky), done (sticky).
module line_follower_ctrl #(
    parameter int N_SENSORS       = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PWM_WIDTH       = 8,
    parameter int LOST_TIMEOUT    = 1000,
    parameter int MARK_W          = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] sensors,
    input  logic [MARK_W-1:0]    stop_marks,
    input  logic [PWM_WIDTH-1:0] speed_fast,
    input  logic [PWM_WIDTH-1:0] speed_slow,
    output logic                 in1,
    output logic                 in2,
    output logic                 in3,
    output logic                 in4,
    output logic                 ena,
    output logic                 enb,
    output logic [MARK_W-1:0]    marker_count,
    output logic                 lost,
    output logic                 done
);
    localparam int C     = N_SENSORS / 2;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_W = $clog2(LOST_TIMEOUT + 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOST_TIMEOUT - 1);
    localparam logic [3:0] CODE_FWD   = 4'b1001;
    localparam logic [3:0] CODE_RIGHT = 4'b0101;
    localparam logic [3:0] CODE_LEFT  = 4'b1010;
    localparam logic [3:0] CODE_STOP  = 4'b1111;

    typedef enum logic [2:0] {S_IDLE, S_FWD, S_RIGHT, S_LEFT, S_CROSS, S_SEARCH, S_HALT} state_t;
    typedef enum logic [2:0] {C_NONE, C_FWD, C_RIGHT, C_LEFT, C_CROSS} cls_t;

    logic [N_SENSORS-1:0] r_sync1, r_sync2, r_cand, r_filt;
    logic [DB_W-1:0]      r_db_cnt, w_db_cnt_nxt;
    state_t               r_state, w_nxt;
    cls_t                 w_cls;
    logic                 w_any_low, w_any_high;
    logic [TMR_W-1:0]     r_tmr, w_tmr_nxt;
    logic [MARK_W-1:0]    r_mark, w_mark_inc;
    logic                 r_lost, r_done, w_lost_set, w_done_set, w_cross_entry;
    logic [3:0]           r_dir, w_dir_nxt;
    logic [PWM_WIDTH-1:0] r_pwm_cnt, w_pwm_nxt, r_duty_a, r_duty_b, w_duty_a_nxt, w_duty_b_nxt, w_target;
    logic                 r_ena, r_enb;

    assign {in1, in2, in3, in4} = r_dir;
    assign ena          = r_ena;
    assign enb          = r_enb;
    assign marker_count = r_mark;
    assign lost         = r_lost;
    assign done         = r_done;

    function automatic state_t cls2state(input cls_t c);
        case (c)
            C_CROSS: cls2state = S_CROSS;
            C_FWD:   cls2state = S_FWD;
            C_RIGHT: cls2state = S_RIGHT;
            C_LEFT:  cls2state = S_LEFT;
            default: cls2state = S_SEARCH;
        endcase
    endfunction

    // Run-length of the synchronised vector; the filter accepts it once DEBOUNCE_CYCLES samples agree.
    always_comb begin
        if (r_sync2 != r_cand)
            w_db_cnt_nxt = DB_W'(1);
        else if (r_db_cnt == DB_MAX)
            w_db_cnt_nxt = r_db_cnt;
        else
            w_db_cnt_nxt = r_db_cnt + 1'b1;
    end

    // Classification of the filtered vector; centre sensor wins over the sides.
    always_comb begin
        w_any_low  = 1'b0;
        w_any_high = 1'b0;
        for (int i = 0; i < C; i++)
            w_any_low = w_any_low | r_filt[i];
        for (int i = C + 1; i < N_SENSORS; i++)
            w_any_high = w_any_high | r_filt[i];
        if (&r_filt)        w_cls = C_CROSS;
        else if (r_filt[C]) w_cls = C_FWD;
        else if (w_any_low) w_cls = C_RIGHT;
        else if (w_any_high) w_cls = C_LEFT;
        else                w_cls = C_NONE;
    end

    assign w_mark_inc = (&r_mark) ? r_mark : r_mark + 1'b1;

    always_comb begin
        w_nxt      = r_state;
        w_tmr_nxt  = '0;
        w_lost_set = 1'b0;
        if (!enable) begin
            w_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:                   w_nxt = S_FWD;
                S_FWD, S_RIGHT, S_LEFT,
                S_CROSS:                  w_nxt = cls2state(w_cls);
                S_SEARCH: begin
                    if (w_cls != C_NONE) begin
                        w_nxt = cls2state(w_cls);
                    end else if (r_tmr == TMR_LAST) begin
                        w_nxt      = S_HALT;
                        w_lost_set = 1'b1;
                    end else begin
                        w_tmr_nxt = r_tmr + 1'b1;
                    end
                end
                S_HALT:                   w_nxt = S_HALT;
                default:                  w_nxt = S_IDLE;
            endcase
        end
        // Only the first cycle of a contiguous crossing counts; the final mark halts straight away.
        w_cross_entry = (w_nxt == S_CROSS) && (r_state != S_CROSS);
        w_done_set    = w_cross_entry && (stop_marks != '0) && (w_mark_inc == stop_marks);
        if (w_done_set)
            w_nxt = S_HALT;
    end

    always_comb begin
        case (w_nxt)
            S_FWD, S_CROSS: w_dir_nxt = CODE_FWD;
            S_RIGHT:        w_dir_nxt = CODE_RIGHT;
            S_LEFT:         w_dir_nxt = CODE_LEFT;
            S_SEARCH:       w_dir_nxt = r_dir;  // keep steering the way the line was last seen
            default:        w_dir_nxt = CODE_STOP;
        endcase
    end

    // Duties follow the state being entered; they change only at the period boundary except for stops.
    always_comb begin
        case (w_nxt)
            S_FWD, S_CROSS:             w_target = speed_fast;
            S_RIGHT, S_LEFT, S_SEARCH:  w_target = speed_slow;
            default:                    w_target = '0;
        endcase
        w_pwm_nxt    = r_pwm_cnt + 1'b1;
        w_duty_a_nxt = r_duty_a;
        w_duty_b_nxt = r_duty_b;
        if (w_nxt == S_IDLE || w_nxt == S_HALT) begin
            w_duty_a_nxt = '0;
            w_duty_b_nxt = '0;
        end else if (&r_pwm_cnt) begin
            w_duty_a_nxt = w_target;
            w_duty_b_nxt = w_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_cand    <= '0;
            r_filt    <= '0;
            r_db_cnt  <= '0;
            r_state   <= S_IDLE;
            r_tmr     <= '0;
            r_mark    <= '0;
            r_lost    <= 1'b0;
            r_done    <= 1'b0;
            r_dir     <= CODE_STOP;
            r_pwm_cnt <= '0;
            r_duty_a  <= '0;
            r_duty_b  <= '0;
            r_ena     <= 1'b0;
            r_enb     <= 1'b0;
        end else begin
            r_sync1  <= sensors;
            r_sync2  <= r_sync1;
            r_cand   <= r_sync2;
            r_db_cnt <= w_db_cnt_nxt;
            if (w_db_cnt_nxt == DB_MAX)
                r_filt <= r_sync2;

            r_state <= w_nxt;
            r_tmr   <= w_tmr_nxt;
            r_dir   <= w_dir_nxt;
            if (r_state == S_IDLE && w_nxt == S_FWD) begin
                r_mark <= '0;
                r_lost <= 1'b0;
                r_done <= 1'b0;
            end else begin
                if (w_cross_entry) r_mark <= w_mark_inc;
                if (w_done_set)    r_done <= 1'b1;
                if (w_lost_set)    r_lost <= 1'b1;
            end

            r_pwm_cnt <= w_pwm_nxt;
            r_duty_a  <= w_duty_a_nxt;
            r_duty_b  <= w_duty_b_nxt;
            r_ena     <= (w_pwm_nxt < w_duty_a_nxt);
            r_enb     <= (w_pwm_nxt < w_duty_b_nxt);
        end
    end
endmodule

// File: tb/tb_line_follower_ctrl.sv
module tb_line_follower_ctrl;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 3 sensors, short search timeout.
    logic       a_en, a_in1, a_in2, a_in3, a_in4, a_ena, a_enb, a_lost, a_done;
    logic [2:0] a_sens;
    logic [3:0] a_stop, a_mark;
    logic [7:0] a_fast, a_slow;
    wire  [3:0] a_code = {a_in1, a_in2, a_in3, a_in4};

    // Instance B: 5 sensors, default timeout.
    logic       b_en, b_in1, b_in2, b_in3, b_in4, b_ena, b_enb, b_lost, b_done;
    logic [4:0] b_sens;
    logic [3:0] b_stop, b_mark;
    logic [7:0] b_fast, b_slow;
    wire  [3:0] b_code = {b_in1, b_in2, b_in3, b_in4};

    int checks = 0;
    int errors = 0;

    line_follower_ctrl #(.N_SENSORS(3), .DEBOUNCE_CYCLES(D), .PWM_WIDTH(8), .LOST_TIMEOUT(20), .MARK_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .enable(a_en), .sensors(a_sens), .stop_marks(a_stop),
        .speed_fast(a_fast), .speed_slow(a_slow),
        .in1(a_in1), .in2(a_in2), .in3(a_in3), .in4(a_in4), .ena(a_ena), .enb(a_enb),
        .marker_count(a_mark), .lost(a_lost), .done(a_done));

    line_follower_ctrl #(.N_SENSORS(5), .DEBOUNCE_CYCLES(D), .PWM_WIDTH(8), .LOST_TIMEOUT(1000), .MARK_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(b_en), .sensors(b_sens), .stop_marks(b_stop),
        .speed_fast(b_fast), .speed_slow(b_slow),
        .in1(b_in1), .in2(b_in2), .in3(b_in3), .in4(b_in4), .ena(b_ena), .enb(b_enb),
        .marker_count(b_mark), .lost(b_lost), .done(b_done));

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int hi_a, hi_b;
        a_en = 1'b1; a_sens = 3'b010; a_stop = 4'd0; a_fast = 8'd128; a_slow = 8'd64;
        b_en = 1'b0; b_sens = 5'b00100; b_stop = 4'd0; b_fast = 8'd200; b_slow = 8'd50;
        rst_n = 1'b0;
        tick(3);
        checks++;
        if (a_code !== 4'b1111 || a_ena !== 1'b0 || a_enb !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got code=%b ena=%b enb=%b, want 1111 0 0", a_code, a_ena, a_enb);
        end
        checks++;
        if (a_mark !== 4'd0 || a_lost !== 1'b0 || a_done !== 1'b0) begin
            errors++; $display("FAIL reset_status: got mark=%0d lost=%b done=%b, want 0 0 0", a_mark, a_lost, a_done);
        end
        rst_n = 1'b1;
        tick(D + 3);
        checks++;
        if (a_code !== 4'b1001) begin
            errors++; $display("FAIL reset_fwd_latency: got %b want 1001", a_code);
        end
        hi_a = 0; hi_b = 0;
        for (int e = D + 4; e <= 255; e++) begin
            tick(1); hi_a += int'(a_ena); hi_b += int'(a_enb);
        end
        checks++;
        if (hi_a != 0 || hi_b != 0) begin
            errors++; $display("FAIL first_period_duty: got ena=%0d enb=%0d highs, want 0", hi_a, hi_b);
        end
        hi_a = 0; hi_b = 0;
        for (int e = 256; e <= 511; e++) begin
            tick(1); hi_a += int'(a_ena); hi_b += int'(a_enb);
        end
        checks++;
        if (hi_a != 128 || hi_b != 128) begin
            errors++; $display("FAIL fast_duty: got ena=%0d enb=%0d highs, want 128", hi_a, hi_b);
        end
    endtask

    task automatic test_glitch();
        int bad, hi_a, hi_b;
        a_sens = 3'b001;
        tick(3);
        a_sens = 3'b010;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (a_code !== 4'b1001) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL glitch_reject: %0d cycles left 1001, want 0", bad);
        end
        a_sens = 3'b001;
        tick(D + 2);
        checks++;
        if (a_code !== 4'b1001) begin
            errors++; $display("FAIL right_too_early: got %b want 1001", a_code);
        end
        tick(1);
        checks++;
        if (a_code !== 4'b0101) begin
            errors++; $display("FAIL right_code: got %b want 0101", a_code);
        end
        tick(300);
        hi_a = 0; hi_b = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1); hi_a += int'(a_ena); hi_b += int'(a_enb);
        end
        checks++;
        if (hi_a != 64 || hi_b != 64) begin
            errors++; $display("FAIL slow_duty: got ena=%0d enb=%0d highs, want 64", hi_a, hi_b);
        end
    endtask

    task automatic test_cross();
        int hi;
        a_stop = 4'd2; a_sens = 3'b010;
        tick(20);
        a_sens = 3'b111; tick(10); a_sens = 3'b010; tick(20);
        checks++;
        if (a_mark !== 4'd1 || a_done !== 1'b0 || a_code !== 4'b1001) begin
            errors++; $display("FAIL first_mark: got mark=%0d done=%b code=%b, want 1 0 1001", a_mark, a_done, a_code);
        end
        a_sens = 3'b111; tick(10); a_sens = 3'b010; tick(20);
        checks++;
        if (a_mark !== 4'd2 || a_done !== 1'b1 || a_code !== 4'b1111) begin
            errors++; $display("FAIL stop_at_mark: got mark=%0d done=%b code=%b, want 2 1 1111", a_mark, a_done, a_code);
        end
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1); hi += int'(a_ena) + int'(a_enb);
        end
        checks++;
        if (hi != 0 || a_code !== 4'b1111) begin
            errors++; $display("FAIL halt_hold: got %0d enable highs code=%b, want 0 1111", hi, a_code);
        end
        a_en = 1'b0; tick(1);
        a_stop = 4'd0; a_en = 1'b1; tick(1);
        checks++;
        if (a_mark !== 4'd0 || a_done !== 1'b0) begin
            errors++; $display("FAIL reenable_clear: got mark=%0d done=%b, want 0 0", a_mark, a_done);
        end
        tick(20);
        a_sens = 3'b111; tick(50); a_sens = 3'b010; tick(20);
        checks++;
        if (a_mark !== 4'd1 || a_code !== 4'b1001) begin
            errors++; $display("FAIL long_cross_once: got mark=%0d code=%b, want 1 1001", a_mark, a_code);
        end
    endtask

    task automatic test_enable_drop();
        int waited;
        tick(600);
        waited = 0;
        while (a_ena !== 1'b1 && waited < 600) begin
            tick(1); waited++;
        end
        checks++;
        if (a_ena !== 1'b1) begin
            errors++; $display("FAIL wait_ena_high: got ena=%b after %0d cycles, want 1", a_ena, waited);
        end
        tick(3);
        a_en = 1'b0; tick(1);
        checks++;
        if (a_code !== 4'b1111 || a_ena !== 1'b0 || a_enb !== 1'b0 || a_mark !== 4'd1) begin
            errors++; $display("FAIL enable_drop: got code=%b ena=%b enb=%b mark=%0d, want 1111 0 0 1",
                               a_code, a_ena, a_enb, a_mark);
        end
        a_en = 1'b1; tick(1);
        checks++;
        if (a_mark !== 4'd0) begin
            errors++; $display("FAIL reenable_mark: got %0d want 0", a_mark);
        end
    endtask

    task automatic test_lost();
        a_sens = 3'b100; tick(20);
        checks++;
        if (a_code !== 4'b1010) begin
            errors++; $display("FAIL left_code: got %b want 1010", a_code);
        end
        a_sens = 3'b000;
        tick(D + 22);
        checks++;
        if (a_code !== 4'b1010 || a_lost !== 1'b0) begin
            errors++; $display("FAIL search_last_cycle: got code=%b lost=%b, want 1010 0", a_code, a_lost);
        end
        tick(1);
        checks++;
        if (a_code !== 4'b1111 || a_lost !== 1'b1 || a_ena !== 1'b0) begin
            errors++; $display("FAIL lost_halt: got code=%b lost=%b ena=%b, want 1111 1 0", a_code, a_lost, a_ena);
        end
        a_en = 1'b0; a_sens = 3'b100; tick(20);
        checks++;
        if (a_lost !== 1'b1 || a_code !== 4'b1111) begin
            errors++; $display("FAIL lost_sticky_idle: got lost=%b code=%b, want 1 1111", a_lost, a_code);
        end
        a_en = 1'b1; tick(1);
        checks++;
        if (a_lost !== 1'b0) begin
            errors++; $display("FAIL lost_clear: got %b want 0", a_lost);
        end
        tick(20);
        a_sens = 3'b000; tick(15); a_sens = 3'b100; tick(40);
        checks++;
        if (a_code !== 4'b1010 || a_lost !== 1'b0) begin
            errors++; $display("FAIL search_recover: got code=%b lost=%b, want 1010 0", a_code, a_lost);
        end
    endtask

    task automatic test_n5_fixed();
        logic [4:0] vecs [4]  = '{5'b00011, 5'b11000, 5'b11111, 5'b00100};
        logic [3:0] codes [4] = '{4'b0101, 4'b1010, 4'b1001, 4'b1001};
        b_en = 1'b1; tick(20);
        for (int i = 0; i < 4; i++) begin
            b_sens = vecs[i]; tick(20);
            checks++;
            if (b_code !== codes[i]) begin
                errors++; $display("FAIL n5_class_%0d: vec=%b got %b want %b", i, vecs[i], b_code, codes[i]);
            end
        end
        checks++;
        if (b_mark !== 4'd1) begin
            errors++; $display("FAIL n5_mark: got %0d want 1", b_mark);
        end
    endtask

    // Steady-state reference: hold each vector long enough for filtering and a full PWM period, then
    // compare the direction code, the measured duty and the crossing count against the rules.
    task automatic test_random();
        int         m_mark = 1;
        bit         prev_cross = 1'b0, prev_none = 1'b0;
        logic [3:0] last_code = 4'b1001;
        logic [3:0] exp_code;
        int         exp_duty, hi_a, hi_b, v;
        for (int it = 0; it < 14; it++) begin
            v = int'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) v = ($urandom_range(0, 1) == 0) ? 0 : 31;
            if (prev_none && v == 0) v = 4;
            b_fast = (it == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            b_slow = (it == 1) ? 8'd0   : 8'($urandom_range(0, 255));
            b_sens = 5'(v);
            if (v == 31) begin
                exp_code = 4'b1001; exp_duty = int'(b_fast);
                if (!prev_cross && m_mark < 15) m_mark++;
            end else if ((v & 4) != 0) begin
                exp_code = 4'b1001; exp_duty = int'(b_fast);
            end else if ((v & 3) != 0) begin
                exp_code = 4'b0101; exp_duty = int'(b_slow);
            end else if ((v & 24) != 0) begin
                exp_code = 4'b1010; exp_duty = int'(b_slow);
            end else begin
                exp_code = last_code; exp_duty = int'(b_slow);
            end
            if (v != 0) last_code = exp_code;
            prev_cross = (v == 31);
            prev_none  = (v == 0);
            tick(300);
            hi_a = 0; hi_b = 0;
            for (int i = 0; i < 256; i++) begin
                tick(1); hi_a += int'(b_ena); hi_b += int'(b_enb);
            end
            checks++;
            if (b_code !== exp_code) begin
                errors++; $display("FAIL rand_code[%0d]: vec=%b got %b want %b", it, 5'(v), b_code, exp_code);
            end
            checks++;
            if (hi_a != exp_duty || hi_b != exp_duty) begin
                errors++; $display("FAIL rand_duty[%0d]: vec=%b got ena=%0d enb=%0d want %0d", it, 5'(v), hi_a, hi_b, exp_duty);
            end
            checks++;
            if (int'(b_mark) != m_mark) begin
                errors++; $display("FAIL rand_mark[%0d]: got %0d want %0d", it, b_mark, m_mark);
            end
            checks++;
            if (b_lost !== 1'b0 || b_done !== 1'b0) begin
                errors++; $display("FAIL rand_status[%0d]: got lost=%b done=%b want 0 0", it, b_lost, b_done);
            end
        end
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0; tick(1);
        checks++;
        if (b_code !== 4'b1111 || b_mark !== 4'd0 || b_ena !== 1'b0 || a_code !== 4'b1111 || a_ena !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got b_code=%b b_mark=%0d b_ena=%b a_code=%b a_ena=%b, want 1111 0 0 1111 0",
                               b_code, b_mark, b_ena, a_code, a_ena);
        end
        rst_n = 1'b1; tick(2);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_cross();
        test_enable_drop();
        test_lost();
        test_n5_fixed();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
